rd_skew_control: RTL and testbench

//  Parametrised read sequencer feeding the systolic array from the per-row memory banks.
//  On a start handshake it emits a diagonally skewed read-enable wavefront.

---
 rtl/rd_skew_control.sv | 130 +++++++++++++
 tb/tb_rd_skew_control.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rd_skew_control.sv
// Skewed read sequencer: diagonal rd_en/rd_addr wavefront into the systolic array, then wr_active and done pulses.
// Latency: start sampled at E0, lane 0 reads the cycle after (t=0); wr_active at t=WR_DELAY, done at max(num_rows+WIDTH_HEIGHT-1, WR_DELAY+1).
// Backpressure: none downstream; start is honoured only while busy==0 (IDLE or the done cycle), otherwise dropped.
// Optional build macro RD_SKEW_ABORT_EN adds an abort input that cancels a running sequence without a done pulse.
module rd_skew_control #(
  parameter int WIDTH_HEIGHT = 16,
  parameter int ADDR_WIDTH   = 8,
  parameter int WR_DELAY     = WIDTH_HEIGHT + 1
) (
  input  logic                               clk,
  input  logic                               reset_n,
`ifdef RD_SKEW_ABORT_EN
  input  logic                               abort,
`endif
  input  logic                               start,
  input  logic [ADDR_WIDTH-1:0]              base_addr,
  input  logic [ADDR_WIDTH:0]                num_rows,
  output logic                               busy,
  output logic                               done,
  output logic [WIDTH_HEIGHT-1:0]            rd_en,
  output logic [WIDTH_HEIGHT*ADDR_WIDTH-1:0] rd_addr,
  output logic                               wr_active
);

  // Counter must hold the largest done time without wrapping.
  localparam int RD_SPAN = (1 << ADDR_WIDTH) + WIDTH_HEIGHT;
  localparam int T_MAX   = (RD_SPAN > WR_DELAY + 2) ? RD_SPAN : WR_DELAY + 2;
  localparam int CNT_W   = $clog2(T_MAX + 1);

  typedef enum logic [1:0] {IDLE, READ, WAIT, DONE} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [ADDR_WIDTH-1:0]   base_q;
  logic [ADDR_WIDTH:0]     nrows_q;

  logic                               accept;
  logic [ADDR_WIDTH-1:0]              base_sel;
  logic [ADDR_WIDTH:0]                nr_sel;
  logic [CNT_W-1:0]                   t_nxt;
  logic [CNT_W-1:0]                   nr_ext;
  logic [CNT_W-1:0]                   t_last_rd;
  logic [CNT_W-1:0]                   t_done;
  logic [WIDTH_HEIGHT-1:0]            rd_en_nxt;
  logic [WIDTH_HEIGHT*ADDR_WIDTH-1:0] rd_addr_nxt;
  logic                               wr_nxt;
  logic                               done_nxt;
  logic                               busy_nxt;
  state_t                             state_nxt;

  // Next-cycle view of the wavefront: t_nxt is the cycle index the registered outputs will show.
  always_comb begin
    accept      = start && ((state == IDLE) || (state == DONE));
    base_sel    = accept ? base_addr : base_q;
    nr_sel      = accept ? num_rows : nrows_q;
    t_nxt       = accept ? '0 : cnt + CNT_W'(1);
    nr_ext      = CNT_W'(nr_sel);
    // Last lane reads at num_rows+WIDTH_HEIGHT-2; only meaningful when num_rows != 0.
    t_last_rd   = nr_ext + CNT_W'(WIDTH_HEIGHT - 2);
    if (nr_sel == '0)
      t_done = '0;
    else if (t_last_rd > CNT_W'(WR_DELAY))
      t_done = t_last_rd + CNT_W'(1);
    else
      t_done = CNT_W'(WR_DELAY + 1);
    rd_en_nxt   = '0;
    rd_addr_nxt = '0;
    for (int i = 0; i < WIDTH_HEIGHT; i++) begin
      rd_en_nxt[i] = (t_nxt >= CNT_W'(i)) && (t_nxt < nr_ext + CNT_W'(i));
      rd_addr_nxt[i*ADDR_WIDTH +: ADDR_WIDTH] =
        rd_en_nxt[i] ? (base_sel + ADDR_WIDTH'(t_nxt) - ADDR_WIDTH'(i)) : '0;
    end
    wr_nxt    = (nr_sel != '0) && (t_nxt == CNT_W'(WR_DELAY));
    done_nxt  = (t_nxt == t_done);
    busy_nxt  = (t_nxt < t_done);
    if (done_nxt)
      state_nxt = DONE;
    else if (t_nxt <= t_last_rd)
      state_nxt = READ;
    else
      state_nxt = WAIT;
  end

  // Sequencer FSM with registered outputs; DONE falls back to IDLE unless a new start arrives.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      base_q    <= '0;
      nrows_q   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= '0;
      rd_addr   <= '0;
      wr_active <= 1'b0;
    end
`ifdef RD_SKEW_ABORT_EN
    else if (abort && (state != IDLE)) begin
      // Cancel silently: no done pulse for an aborted sequence.
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= '0;
      rd_addr   <= '0;
      wr_active <= 1'b0;
    end
`endif
    else if (accept || (state == READ) || (state == WAIT)) begin
      if (accept) begin
        base_q  <= base_addr;
        nrows_q <= num_rows;
      end
      state     <= state_nxt;
      cnt       <= t_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      rd_en     <= rd_en_nxt;
      rd_addr   <= rd_addr_nxt;
      wr_active <= wr_nxt;
    end else begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= '0;
      rd_addr   <= '0;
      wr_active <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rd_skew_control.sv
// Directed bench for rd_skew_control: table of sequences plus hand-written corner cases.
// Latency: outputs sampled on the falling edge; the first falling edge after the start edge is t=0.
// Backpressure: not applicable; start re-pulses while busy are expected to be dropped.
module tb_rd_skew_control;
  localparam int WH = 16;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic          start2;
  logic [AW-1:0] base_addr;
  logic [AW:0]   num_rows;

  logic             busy, done, wr_active;
  logic [WH-1:0]    rd_en;
  logic [WH*AW-1:0] rd_addr;
  logic             busy2, done2, wr_active2;
  logic [WH-1:0]    rd_en2;
  logic [WH*AW-1:0] rd_addr2;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int base;
    int nrows;
    int exp_done;
    int exp_wr;     // -1: no pulse expected
    int exp_reads;  // total rd_en bits over the whole sequence
  } vec_t;

  vec_t          vecs[7];
  logic [AW-1:0] cap_l0[8];
  logic [AW-1:0] cap_l3[8];
  logic [AW-1:0] t2_exp[4];
  logic [WH-1:0] snap[5];
  logic [WH-1:0] snap_exp[5];
  int            snap_t[5];
  int            d, w, wc, r, we, last_rd, wait_busy;

  rd_skew_control #(.WIDTH_HEIGHT(WH), .ADDR_WIDTH(AW), .WR_DELAY(WH + 1)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr), .num_rows(num_rows),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .wr_active(wr_active)
  );

  rd_skew_control #(.WIDTH_HEIGHT(WH), .ADDR_WIDTH(AW), .WR_DELAY(40)) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start2), .base_addr(base_addr), .num_rows(num_rows),
    .busy(busy2), .done(done2), .rd_en(rd_en2), .rd_addr(rd_addr2), .wr_active(wr_active2)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] lane_addr(input logic [WH*AW-1:0] v, input int i);
    return v[i*AW +: AW];
  endfunction

  // Count disagreements between one sampled cycle and the diagonal-wavefront rule.
  function automatic int wave_errs(input int t, input int b, input int n, input int td,
                                   input logic [WH-1:0] en, input logic [WH*AW-1:0] ad,
                                   input logic bz);
    int            errs;
    logic          exp_en;
    logic [AW-1:0] exp_a;
    errs = 0;
    for (int i = 0; i < WH; i++) begin
      exp_en = (t >= i) && (t < i + n);
      exp_a  = exp_en ? AW'(b + t - i) : '0;
      if (en[i] !== exp_en) errs++;
      if (lane_addr(ad, i) !== exp_a) errs++;
    end
    if (bz !== (t < td)) errs++;
    return errs;
  endfunction

  task automatic run_vec(input vec_t v, output int done_t, output int wr_t, output int wr_cnt,
                         output int reads, output int werr);
    done_t = -1; wr_t = -1; wr_cnt = 0; reads = 0; werr = 0;
    @(negedge clk);
    start = 1'b1; base_addr = AW'(v.base); num_rows = (AW+1)'(v.nrows);
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < 400; t++) begin
      werr += wave_errs(t, v.base, v.nrows, v.exp_done, rd_en, rd_addr, busy);
      if (t < 8) begin
        cap_l0[t] = lane_addr(rd_addr, 0);
        cap_l3[t] = lane_addr(rd_addr, 3);
      end
      if (wr_active === 1'b1) begin
        if (wr_cnt == 0) wr_t = t;
        wr_cnt++;
      end
      reads += $countones(rd_en);
      if (done === 1'b1) begin
        done_t = t;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; start2 = 1'b0; base_addr = '0; num_rows = '0;
    vecs[0] = '{base: 8'h00, nrows: 16,  exp_done: 31,  exp_wr: 17, exp_reads: 256};
    vecs[1] = '{base: 8'hFE, nrows: 4,   exp_done: 19,  exp_wr: 17, exp_reads: 64};
    vecs[2] = '{base: 8'h55, nrows: 0,   exp_done: 0,   exp_wr: -1, exp_reads: 0};
    vecs[3] = '{base: 8'h10, nrows: 1,   exp_done: 18,  exp_wr: 17, exp_reads: 16};
    vecs[4] = '{base: 8'hA0, nrows: 2,   exp_done: 18,  exp_wr: 17, exp_reads: 32};
    vecs[5] = '{base: 8'h33, nrows: 3,   exp_done: 18,  exp_wr: 17, exp_reads: 48};
    vecs[6] = '{base: 8'h80, nrows: 256, exp_done: 271, exp_wr: 17, exp_reads: 4096};
    t2_exp[0] = 8'hFE; t2_exp[1] = 8'hFF; t2_exp[2] = 8'h00; t2_exp[3] = 8'h01;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_wr_active", wr_active, 0);
    chk("rst_dut2", {busy2, done2, wr_active2, rd_en2, rd_addr2}, 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_after_rst", {busy, done, wr_active, rd_en}, 0);

    // Table-driven sequences.
    for (int k = 0; k < 7; k++) begin
      run_vec(vecs[k], d, w, wc, r, we);
      chk($sformatf("v%0d_done_t", k), d, vecs[k].exp_done);
      chk($sformatf("v%0d_wr_t", k), w, vecs[k].exp_wr);
      chk($sformatf("v%0d_wr_pulses", k), wc, (vecs[k].exp_wr < 0) ? 0 : 1);
      chk($sformatf("v%0d_reads", k), r, vecs[k].exp_reads);
      chk($sformatf("v%0d_wave_errs", k), we, 0);
      if (k == 1) begin
        for (int j = 0; j < 4; j++) begin
          chk($sformatf("t2_lane0_t%0d", j), cap_l0[j], t2_exp[j]);
          chk($sformatf("t2_lane3_t%0d", j + 3), cap_l3[j + 3], t2_exp[j]);
        end
      end
    end

    // T5: start re-pulsed while busy is ignored, then start in the done cycle is taken.
    snap_t[0] = 0;  snap_exp[0] = 16'h0001;
    snap_t[1] = 1;  snap_exp[1] = 16'h0003;
    snap_t[2] = 15; snap_exp[2] = 16'hFFFF;
    snap_t[3] = 16; snap_exp[3] = 16'hFFFE;
    snap_t[4] = 30; snap_exp[4] = 16'h8000;
    for (int j = 0; j < 5; j++) snap[j] = '0;
    @(negedge clk);
    start = 1'b1; base_addr = 8'h00; num_rows = 9'd16;
    @(negedge clk);
    start = 1'b0;
    d = -1; we = 0; w = -1;
    for (int t = 0; t < 40; t++) begin
      we += wave_errs(t, 8'h00, 16, 31, rd_en, rd_addr, busy);
      for (int j = 0; j < 5; j++) if (snap_t[j] == t) snap[j] = rd_en;
      if (wr_active === 1'b1) w = t;
      if (done === 1'b1) begin
        d = t;
        start = 1'b1; base_addr = 8'h40; num_rows = 9'd3;
        break;
      end
      if (t == 5 || t == 10) begin
        start = 1'b1; base_addr = 8'hC3; num_rows = 9'd5;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    chk("t5_done_t", d, 31);
    chk("t5_wr_t", w, 17);
    chk("t5_wave_errs", we, 0);
    for (int j = 0; j < 5; j++) chk($sformatf("t5_rd_en_t%0d", snap_t[j]), snap[j], snap_exp[j]);
    @(negedge clk);
    start = 1'b0;
    chk("t5_restart_rd_en", rd_en, 16'h0001);
    chk("t5_restart_addr0", lane_addr(rd_addr, 0), 8'h40);
    chk("t5_restart_busy", busy, 1);
    d = -1;
    for (int t = 0; t < 40; t++) begin
      if (done === 1'b1) begin
        d = t;
        break;
      end
      @(negedge clk);
    end
    chk("t5_restart_done_t", d, 18);

    // T6: asynchronous reset mid-sequence.
    @(negedge clk);
    start = 1'b1; base_addr = 8'h20; num_rows = 9'd16;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    chk("t6_rd_en_t8", rd_en, 16'h01FF);
    chk("t6_busy_t8", busy, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_async_busy", busy, 0);
    chk("t6_async_rd_en", rd_en, 0);
    chk("t6_async_rd_addr", rd_addr, 0);
    chk("t6_async_flags", {done, wr_active}, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    we = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if ({busy, done, wr_active, rd_en} !== '0) we++;
    end
    chk("t6_not_resumed", we, 0);

    // T4: WR_DELAY past the read window, WAIT bridges the gap.
    @(negedge clk);
    start2 = 1'b1; base_addr = 8'h30; num_rows = 9'd2;
    @(negedge clk);
    start2 = 1'b0;
    d = -1; w = -1; wc = 0; last_rd = -1; wait_busy = 0; we = 0;
    for (int t = 0; t < 80; t++) begin
      we += wave_errs(t, 8'h30, 2, 41, rd_en2, rd_addr2, busy2);
      if (rd_en2 !== '0) last_rd = t;
      if (t == 40) wait_busy = busy2;
      if (wr_active2 === 1'b1) begin
        if (wc == 0) w = t;
        wc++;
      end
      if (done2 === 1'b1) begin
        d = t;
        break;
      end
      @(negedge clk);
    end
    chk("t4_last_read_t", last_rd, 16);
    chk("t4_wr_t", w, 40);
    chk("t4_wr_pulses", wc, 1);
    chk("t4_busy_t40", wait_busy, 1);
    chk("t4_done_t", d, 41);
    chk("t4_wave_errs", we, 0);
    @(negedge clk);
    chk("t4_idle_after", {busy2, done2, rd_en2}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
